aes_key_expand: RTL and testbench

Iterative AES-128 key schedule. Accepts a 128-bit cipher key and streams the 11 round keys (round 0..10) to the round datapath over a valid/ready interface, one per handshake. It instantiates four sbox instances for SubWord and sits directly upstream of the round stages, which consume each round key as it is produced.

---
 rtl/aes_key_expand.sv | 141 ++++++++++++++
 tb/tb_aes_key_expand.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: accepts a cipher key and streams round keys 0..NUM_ROUNDS
// over a valid/ready interface, one round key per handshake.
module aes_key_expand #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key_in,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         rk_last
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; a producer holds
   // valid and its payload stable until that edge, and valid never depends on ready.

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [7:0]   rcon;
   logic [7:0]   rcon_nxt;
   logic         key_fire;
   logic         rk_fire;
   logic         at_last;
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rot_w3;
   logic [31:0]  sub_w3;
   logic [31:0]  t_word;
   logic [31:0]  n0, n1, n2, n3;

   assign key_fire = key_valid && key_ready;
   assign rk_fire  = rk_valid && rk_ready;
   assign at_last  = (rk_idx == 4'(NUM_ROUNDS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (key_valid) state_nxt = EMIT;
         EMIT: if (rk_ready && at_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Both handshake flags decode the state register only, so they stay registered outputs.
   always_comb begin
      key_ready = 1'b0;
      rk_valid  = 1'b0;
      case (state)
         IDLE: key_ready = 1'b1;
         EMIT: rk_valid  = 1'b1;
         default: key_ready = 1'b0;
      endcase
   end

   assign {w0, w1, w2, w3} = rk_out;
   assign rot_w3 = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .in_byte  (rot_w3[8*i +: 8]),
         .out_byte (sub_w3[8*i +: 8])
      );
   end

   assign t_word   = sub_w3 ^ {rcon, 24'h0};
   assign n0       = w0 ^ t_word;
   assign n1       = w1 ^ n0;
   assign n2       = w2 ^ n1;
   assign n3       = w3 ^ n2;
   assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

   always_ff @(posedge clk) begin
      if (rst) begin
         rk_out  <= '0;
         rk_idx  <= '0;
         rk_last <= 1'b0;
         rcon    <= 8'h01;
      end else if (key_fire) begin
         rk_out  <= key_in;
         rk_idx  <= '0;
         rk_last <= 1'b0;
         rcon    <= 8'h01;
      end else if (rk_fire) begin
         if (at_last) begin
            rk_last <= 1'b0;
         end else begin
            rk_out  <= {n0, n1, n2, n3};
            rk_idx  <= rk_idx + 4'd1;
            rk_last <= (rk_idx == 4'(NUM_ROUNDS - 1));
            rcon    <= rcon_nxt;
         end
      end
   end

endmodule

// AES forward S-box as a combinational lookup table.
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   localparam logic [7:0] SBOX_TABLE [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign out_byte = SBOX_TABLE[in_byte];

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: random keys and backpressure checked against a FIPS-197 style
// word-by-word key expansion whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key_in;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;
   logic         rk_last;

   int total = 0;
   int bad   = 0;

   logic [7:0]   sbox_ref [256];
   logic [127:0] exp_q [$];
   logic [127:0] got_rk [$];
   logic [3:0]   got_idx [$];
   logic         got_last [$];
   int           stall_bad;
   int           valid_cycles;
   bit           collect_timeout;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   aes_key_expand #(.NUM_ROUNDS(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_in    (key_in),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_out    (rk_out),
      .rk_idx    (rk_idx),
      .rk_last   (rk_last)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
      logic [15:0] d;
      d = {v, v} << k;
      return d[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic model_schedule(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
            t = t ^ {rc, 24'h0};
            rc = gf_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      exp_q.delete();
      for (int r = 0; r < 11; r++) exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_key(input logic [127:0] k);
      int n = 0;
      key_in = k;
      key_valid = 1'b1;
      while (!key_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (key_ready !== 1'b1) begin
         bad++;
         $display("FAIL key_accept: key_ready=%b required 1", key_ready);
      end
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic collect(input int ready_pct, input int stall_a, input int stall_b, input bit scramble);
      int         cyc = 0;
      int         hold = 0;
      bit         done_a = 0;
      bit         done_b = 0;
      bit         stalled = 0;
      bit         rdy;
      logic [127:0] prev_rk = '0;
      logic [3:0]   prev_idx = '0;
      got_rk.delete();
      got_idx.delete();
      got_last.delete();
      stall_bad = 0;
      valid_cycles = 0;
      while (got_rk.size() < 11 && cyc < 400) begin
         if (scramble) key_in = {$urandom, $urandom, $urandom, $urandom};
         rdy = 1'b0;
         if (rk_valid === 1'b1) begin
            valid_cycles++;
            if (stalled && (rk_out !== prev_rk || rk_idx !== prev_idx)) stall_bad++;
            if (!done_a && int'(rk_idx) == stall_a) begin hold = 5; done_a = 1; end
            if (!done_b && int'(rk_idx) == stall_b) begin hold = 5; done_b = 1; end
            if (hold > 0) begin
               hold--;
            end else begin
               rdy = ($urandom_range(0, 99) < ready_pct);
            end
            if (rdy) begin
               got_rk.push_back(rk_out);
               got_idx.push_back(rk_idx);
               got_last.push_back(rk_last);
            end
            stalled  = !rdy;
            prev_rk  = rk_out;
            prev_idx = rk_idx;
         end
         rk_ready = rdy;
         @(negedge clk);
         cyc++;
      end
      rk_ready = 1'b0;
      collect_timeout = (got_rk.size() < 11);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      key_valid = 1'b0;
      rk_ready = 1'b0;
      key_in = '0;
      repeat (3) @(negedge clk);
      total++;
      if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== 128'h0 || rk_idx !== 4'd0 || rk_last !== 1'b0) begin
         bad++;
         $display("FAIL reset: ready=%b valid=%b out=%h idx=%0d last=%b required 1 0 0 0 0",
                  key_ready, rk_valid, rk_out, rk_idx, rk_last);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fips_vector();
      model_schedule(FIPS_KEY);
      send_key(FIPS_KEY);
      total++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'd0) begin
         bad++;
         $display("FAIL fips_latency: valid=%b idx=%0d required 1 0", rk_valid, rk_idx);
      end
      collect(100, -1, -1, 0);
      total++;
      if (collect_timeout || valid_cycles != 11) begin
         bad++;
         $display("FAIL fips_cycles: keys=%0d valid_cycles=%0d required 11 11", got_rk.size(), valid_cycles);
      end
      total++;
      if (got_rk.size() < 11 || got_rk[0] !== FIPS_KEY || got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
          got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || got_last[10] !== 1'b1) begin
         bad++;
         $display("FAIL fips_known: rk1=%h rk10=%h required a0fafe1788542cb123a339392a6c7605 d014f9a8c9ee2589e13f0cc8b6630ca6",
                  (got_rk.size() > 1) ? got_rk[1] : 128'h0, (got_rk.size() > 10) ? got_rk[10] : 128'h0);
      end
      for (int i = 0; i < 11; i++) begin
         total++;
         if (got_rk.size() <= i || got_rk[i] !== exp_q[i] || got_idx[i] !== 4'(i) || got_last[i] !== (i == 10)) begin
            bad++;
            $display("FAIL fips_rk%0d: got %h required %h", i, (got_rk.size() > i) ? got_rk[i] : 128'h0, exp_q[i]);
         end
      end
      total++;
      if (rk_valid !== 1'b0 || key_ready !== 1'b1 || rk_last !== 1'b0) begin
         bad++;
         $display("FAIL fips_idle: valid=%b ready=%b last=%b required 0 1 0", rk_valid, key_ready, rk_last);
      end
   endtask

   task automatic test_zero_key();
      model_schedule(128'h0);
      send_key(128'h0);
      collect(100, -1, -1, 0);
      total++;
      if (collect_timeout || got_rk[1] !== 128'h62636363626363636263636362636363 ||
          got_rk[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
         bad++;
         $display("FAIL zero_known: rk1=%h rk10=%h required 62636363626363636263636362636363 b4ef5bcb3e92e21123e951cf6f8f188e",
                  (got_rk.size() > 1) ? got_rk[1] : 128'h0, (got_rk.size() > 10) ? got_rk[10] : 128'h0);
      end
      for (int i = 0; i < 11; i++) begin
         total++;
         if (got_rk.size() <= i || got_rk[i] !== exp_q[i] || got_idx[i] !== 4'(i)) begin
            bad++;
            $display("FAIL zero_rk%0d: got %h required %h", i, (got_rk.size() > i) ? got_rk[i] : 128'h0, exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure(input logic [127:0] key, input int pct);
      model_schedule(key);
      send_key(key);
      collect(pct, 3, 10, 0);
      total++;
      if (collect_timeout || stall_bad != 0) begin
         bad++;
         $display("FAIL bp_stall: keys=%0d unstable_cycles=%0d required 11 0", got_rk.size(), stall_bad);
      end
      for (int i = 0; i < 11; i++) begin
         total++;
         if (got_rk.size() <= i || got_rk[i] !== exp_q[i] || got_idx[i] !== 4'(i) || got_last[i] !== (i == 10)) begin
            bad++;
            $display("FAIL bp_rk%0d: got %h idx %0d required %h idx %0d", i,
                     (got_rk.size() > i) ? got_rk[i] : 128'h0, (got_idx.size() > i) ? got_idx[i] : 4'h0, exp_q[i], i);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] k;
      int n = 0;
      send_key({$urandom, $urandom, $urandom, $urandom});
      rk_ready = 1'b1;
      while (rk_idx !== 4'd6 && n < 30) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (rk_idx !== 4'd6) begin
         bad++;
         $display("FAIL mid_reach6: idx=%0d required 6", rk_idx);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rk_ready = 1'b0;
      total++;
      if (rk_valid !== 1'b0 || rk_out !== 128'h0 || key_ready !== 1'b1 || rk_idx !== 4'd0) begin
         bad++;
         $display("FAIL mid_reset: valid=%b out=%h ready=%b idx=%0d required 0 0 1 0", rk_valid, rk_out, key_ready, rk_idx);
      end
      k = {$urandom, $urandom, $urandom, $urandom};
      model_schedule(k);
      send_key(k);
      collect(70, -1, -1, 0);
      for (int i = 0; i < 11; i++) begin
         total++;
         if (got_rk.size() <= i || got_rk[i] !== exp_q[i] || got_idx[i] !== 4'(i)) begin
            bad++;
            $display("FAIL mid_rk%0d: got %h required %h", i, (got_rk.size() > i) ? got_rk[i] : 128'h0, exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] k1;
      logic [127:0] k2;
      k1 = {$urandom, $urandom, $urandom, $urandom};
      k2 = {$urandom, $urandom, $urandom, $urandom};
      model_schedule(k1);
      rk_ready = 1'b1;
      key_in = k1;
      key_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         total++;
         if (rk_valid !== 1'b1 || key_ready !== 1'b0 || rk_out !== exp_q[i] || rk_idx !== 4'(i)) begin
            bad++;
            $display("FAIL b2b_emit%0d: valid=%b ready=%b out=%h idx=%0d required 1 0 %h %0d",
                     i, rk_valid, key_ready, rk_out, rk_idx, exp_q[i], i);
         end
         key_in = k2;
         @(negedge clk);
      end
      total++;
      if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_idle: valid=%b ready=%b required 0 1", rk_valid, key_ready);
      end
      @(negedge clk);
      key_valid = 1'b0;
      total++;
      if (rk_valid !== 1'b1 || rk_out !== k2 || rk_idx !== 4'd0) begin
         bad++;
         $display("FAIL b2b_second: valid=%b out=%h idx=%0d required 1 %h 0", rk_valid, rk_out, rk_idx, k2);
      end
      model_schedule(k2);
      collect(100, -1, -1, 0);
      for (int i = 0; i < 11; i++) begin
         total++;
         if (got_rk.size() <= i || got_rk[i] !== exp_q[i] || got_idx[i] !== 4'(i)) begin
            bad++;
            $display("FAIL b2b_rk%0d: got %h required %h", i, (got_rk.size() > i) ? got_rk[i] : 128'h0, exp_q[i]);
         end
      end
   endtask

   task automatic test_key_change();
      logic [127:0] k;
      k = {$urandom, $urandom, $urandom, $urandom};
      model_schedule(k);
      send_key(k);
      collect(80, -1, -1, 1);
      for (int i = 0; i < 11; i++) begin
         total++;
         if (got_rk.size() <= i || got_rk[i] !== exp_q[i] || got_idx[i] !== 4'(i)) begin
            bad++;
            $display("FAIL keychg_rk%0d: got %h required %h", i, (got_rk.size() > i) ? got_rk[i] : 128'h0, exp_q[i]);
         end
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips_vector();
      test_zero_key();
      test_backpressure(FIPS_KEY, 60);
      for (int r = 0; r < 4; r++)
         test_backpressure({$urandom, $urandom, $urandom, $urandom}, $urandom_range(30, 100));
      test_reset_mid();
      test_back_to_back();
      test_key_change();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
